// File: rtl/vdp_cpu_port.sv
// CPU side of the VDP: decodes Z80 control/data port accesses into VRAM, CRAM and register writes.
// Define VDP_LINE_IRQ_EN to add the programmable line-counter interrupt (reload via index 10).
module vdp_cpu_port #(
  parameter int unsigned VRAM_LAT = 2,
  parameter int unsigned NUM_REGS = 10
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_cpu_req,
  input  logic                  i_cpu_wr,
  input  logic                  i_cpu_sel,
  input  logic [7:0]            i_cpu_din,
  output logic                  o_cpu_ready,
  output logic [7:0]            o_cpu_dout,
  output logic                  o_cpu_rd_valid,
  input  logic                  i_screenBusy,
  output logic [13:0]           o_VRAM_CPU_addr,
  output logic [7:0]            o_VRAM_CPU_wdata,
  output logic                  o_VRAM_CPU_we,
  output logic                  o_VRAM_CPU_re,
  input  logic [7:0]            i_VRAM_CPU_data_out,
  output logic [4:0]            o_CRAM_CPU_addr,
  output logic [5:0]            o_CRAM_CPU_wdata,
  output logic                  o_CRAM_CPU_we,
  output logic [NUM_REGS*8-1:0] o_regFile,
  input  logic                  i_vblank_pulse,
  input  logic                  i_spr_ovf_pulse,
  input  logic                  i_spr_coll_pulse,
  input  logic                  i_line_pulse,
  output logic                  o_irq
);

  localparam int unsigned LatW = $clog2(VRAM_LAT + 1);

  typedef enum logic [2:0] {StIdle, StVramWr, StCramWr, StRdReq, StRdWait} state_e;

  state_e                r_state, w_state_d;
  logic [13:0]           r_addr;
  logic [1:0]            r_code;
  logic                  r_second;
  logic [7:0]            r_buf;
  logic                  r_vint, r_ovf, r_coll, r_irq;
  logic [7:0]            r_dout;
  logic                  r_rd_valid;
  logic [LatW-1:0]       r_lat_cnt;
  logic [NUM_REGS*8-1:0] r_regs;

  logic w_accept, w_ready, w_vram_we, w_vram_re, w_cram_we;
  logic w_ctrl_wr, w_ctrl_rd, w_data_wr, w_data_rd, w_reg_wr, w_rd_done, w_line_irq;
  logic [7:0] w_status;

  assign w_ctrl_wr = w_accept & i_cpu_sel & i_cpu_wr;
  assign w_ctrl_rd = w_accept & i_cpu_sel & ~i_cpu_wr;
  assign w_data_wr = w_accept & ~i_cpu_sel & i_cpu_wr;
  assign w_data_rd = w_accept & ~i_cpu_sel & ~i_cpu_wr;
  assign w_reg_wr  = w_ctrl_wr & r_second & (i_cpu_din[7:6] == 2'd2);
  assign w_rd_done = (r_state == StRdWait) && (r_lat_cnt == LatW'(VRAM_LAT));
  assign w_status  = {r_vint, r_ovf, r_coll, 5'b0};

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= StIdle;
    else       r_state <= w_state_d;
  end

  always_comb begin
    w_state_d = r_state;
    w_ready   = 1'b0;
    w_accept  = 1'b0;
    w_vram_we = 1'b0;
    w_vram_re = 1'b0;
    w_cram_we = 1'b0;
    case (r_state)
      StIdle: begin
        w_ready  = 1'b1;
        w_accept = i_cpu_req;
        if (i_cpu_req) begin
          if (i_cpu_sel) begin
            if (i_cpu_wr && r_second && (i_cpu_din[7:6] == 2'd0)) w_state_d = StRdReq;
          end else if (i_cpu_wr) begin
            w_state_d = (r_code == 2'd3) ? StCramWr : StVramWr;
          end else begin
            w_state_d = StRdReq;
          end
        end
      end
      StVramWr: begin
        if (!i_screenBusy) begin
          w_vram_we = 1'b1;
          w_state_d = StIdle;
        end
      end
      StCramWr: begin
        w_cram_we = 1'b1;
        w_state_d = StIdle;
      end
      StRdReq: begin
        if (!i_screenBusy) begin
          w_vram_re = 1'b1;
          w_state_d = StRdWait;
        end
      end
      StRdWait: begin
        if (w_rd_done) w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_addr     <= '0;
      r_code     <= '0;
      r_second   <= 1'b0;
      r_buf      <= '0;
      r_vint     <= 1'b0;
      r_ovf      <= 1'b0;
      r_coll     <= 1'b0;
      r_irq      <= 1'b0;
      r_dout     <= '0;
      r_rd_valid <= 1'b0;
      r_lat_cnt  <= '0;
      r_regs     <= '0;
    end else begin
      r_rd_valid <= 1'b0;
      if (w_ctrl_wr) begin
        if (!r_second) begin
          r_addr[7:0] <= i_cpu_din;
          r_second    <= 1'b1;
        end else begin
          r_code       <= i_cpu_din[7:6];
          r_addr[13:8] <= i_cpu_din[5:0];
          r_second     <= 1'b0;
        end
      end
      // Register value comes from the first command byte, still held in addr[7:0].
      if (w_reg_wr) begin
        for (int i = 0; i < NUM_REGS; i++) begin
          if (i_cpu_din[3:0] == 4'(i)) r_regs[i*8 +: 8] <= r_addr[7:0];
        end
      end
      if (w_ctrl_rd || w_data_rd) begin
        r_dout     <= w_ctrl_rd ? w_status : r_buf;
        r_rd_valid <= 1'b1;
        r_second   <= 1'b0;
      end
      if (w_data_wr) begin
        r_second <= 1'b0;
        r_buf    <= i_cpu_din;
      end
      if (w_vram_re)                                   r_lat_cnt <= LatW'(1);
      else if (r_state == StRdWait && !w_rd_done)      r_lat_cnt <= r_lat_cnt + LatW'(1);
      if (w_rd_done)                                   r_buf <= i_VRAM_CPU_data_out;
      if (w_vram_we || w_cram_we || w_rd_done)         r_addr <= r_addr + 14'd1;
      // A pulse arriving with a status read wins over the clear.
      r_vint <= (r_vint & ~w_ctrl_rd) | i_vblank_pulse;
      r_ovf  <= (r_ovf  & ~w_ctrl_rd) | i_spr_ovf_pulse;
      r_coll <= (r_coll & ~w_ctrl_rd) | i_spr_coll_pulse;
      r_irq  <= (r_vint & r_regs[13]) | w_line_irq;
    end
  end

`ifdef VDP_LINE_IRQ_EN
  logic [7:0] r_line_cnt, r_line_reload;
  logic       r_line_flag;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_line_cnt    <= '0;
      r_line_reload <= '0;
      r_line_flag   <= 1'b0;
    end else begin
      if (w_reg_wr && (i_cpu_din[3:0] == 4'd10)) r_line_reload <= r_addr[7:0];
      if (i_vblank_pulse)    r_line_cnt <= r_line_reload;
      else if (i_line_pulse) r_line_cnt <= (r_line_cnt == 8'd0) ? r_line_reload
                                                               : r_line_cnt - 8'd1;
      r_line_flag <= (r_line_flag & ~w_ctrl_rd) |
                     (i_line_pulse & ~i_vblank_pulse & (r_line_cnt == 8'd0));
    end
  end

  assign w_line_irq = r_line_flag & r_regs[4];
`else
  logic w_unused_line;
  assign w_unused_line = i_line_pulse;
  assign w_line_irq    = 1'b0;
`endif

  assign o_cpu_ready      = w_ready;
  assign o_cpu_dout       = r_dout;
  assign o_cpu_rd_valid   = r_rd_valid;
  assign o_VRAM_CPU_addr  = r_addr;
  assign o_VRAM_CPU_wdata = r_buf;
  assign o_VRAM_CPU_we    = w_vram_we;
  assign o_VRAM_CPU_re    = w_vram_re;
  assign o_CRAM_CPU_addr  = r_addr[4:0];
  assign o_CRAM_CPU_wdata = r_buf[5:0];
  assign o_CRAM_CPU_we    = w_cram_we;
  assign o_regFile        = r_regs;
  assign o_irq            = r_irq;

endmodule

// File: tb/tb_vdp_cpu_port.sv
// Bench for vdp_cpu_port: directed scenarios plus randomized port traffic against a
// behavioural model of the command/address/read-ahead rules.
module tb_vdp_cpu_port;
  localparam int unsigned NUM_REGS = 10;

  logic clk = 1'b0;
  logic i_rst, i_cpu_req, i_cpu_wr, i_cpu_sel, i_screenBusy;
  logic [7:0] i_cpu_din;
  logic o_cpu_ready, o_cpu_rd_valid, o_VRAM_CPU_we, o_VRAM_CPU_re, o_CRAM_CPU_we, o_irq;
  logic [7:0] o_cpu_dout, o_VRAM_CPU_wdata, vram_dout;
  logic [13:0] o_VRAM_CPU_addr;
  logic [4:0] o_CRAM_CPU_addr;
  logic [5:0] o_CRAM_CPU_wdata;
  logic [NUM_REGS*8-1:0] o_regFile;
  logic i_vblank_pulse, i_spr_ovf_pulse, i_spr_coll_pulse, i_line_pulse;

  vdp_cpu_port #(.VRAM_LAT(2), .NUM_REGS(NUM_REGS)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_cpu_req(i_cpu_req), .i_cpu_wr(i_cpu_wr),
    .i_cpu_sel(i_cpu_sel), .i_cpu_din(i_cpu_din), .o_cpu_ready(o_cpu_ready),
    .o_cpu_dout(o_cpu_dout), .o_cpu_rd_valid(o_cpu_rd_valid), .i_screenBusy(i_screenBusy),
    .o_VRAM_CPU_addr(o_VRAM_CPU_addr), .o_VRAM_CPU_wdata(o_VRAM_CPU_wdata),
    .o_VRAM_CPU_we(o_VRAM_CPU_we), .o_VRAM_CPU_re(o_VRAM_CPU_re),
    .i_VRAM_CPU_data_out(vram_dout), .o_CRAM_CPU_addr(o_CRAM_CPU_addr),
    .o_CRAM_CPU_wdata(o_CRAM_CPU_wdata), .o_CRAM_CPU_we(o_CRAM_CPU_we),
    .o_regFile(o_regFile), .i_vblank_pulse(i_vblank_pulse),
    .i_spr_ovf_pulse(i_spr_ovf_pulse), .i_spr_coll_pulse(i_spr_coll_pulse),
    .i_line_pulse(i_line_pulse), .o_irq(o_irq)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail = 0;
  int strobe_err = 0;
  logic rand_busy = 1'b0;

  // VRAM behaviour: unwritten cells hold a fixed address hash; data arrives 2 cycles after re.
  logic [7:0]  vram [16384];
  bit          written [16384];
  logic [7:0]  ref_vram [16384];
  logic [7:0]  rd_pipe;
  logic [21:0] we_q [$];
  logic [13:0] re_q [$];
  logic [10:0] cram_q [$];

  always @(posedge clk) begin
    if (o_VRAM_CPU_we) begin
      vram[o_VRAM_CPU_addr]    <= o_VRAM_CPU_wdata;
      written[o_VRAM_CPU_addr] <= 1'b1;
      we_q.push_back({o_VRAM_CPU_addr, o_VRAM_CPU_wdata});
    end
    if (o_VRAM_CPU_re) begin
      re_q.push_back(o_VRAM_CPU_addr);
      rd_pipe <= written[o_VRAM_CPU_addr] ? vram[o_VRAM_CPU_addr] : 8'(o_VRAM_CPU_addr * 37 + 5);
    end else begin
      rd_pipe <= 8'hEE;
    end
    vram_dout <= rd_pipe;
    if (o_CRAM_CPU_we) cram_q.push_back({o_CRAM_CPU_addr, o_CRAM_CPU_wdata});
    if ((o_VRAM_CPU_we && o_VRAM_CPU_re) || ((o_VRAM_CPU_we || o_VRAM_CPU_re) && i_screenBusy))
      strobe_err <= strobe_err + 1;
  end

  function automatic logic [21:0] we_head();
    return (we_q.size() > 0) ? we_q[0] : 22'h3FFFFF;
  endfunction
  function automatic logic [13:0] re_head();
    return (re_q.size() > 0) ? re_q[0] : 14'h3FFF;
  endfunction
  function automatic logic [10:0] cram_head();
    return (cram_q.size() > 0) ? cram_q[0] : 11'h7FF;
  endfunction

  task automatic clear_q();
    we_q.delete(); re_q.delete(); cram_q.delete();
  endtask

  task automatic xfer(input logic wr, input logic sel, input logic [7:0] din, input logic vb,
                      output logic [7:0] dout, output logic rv);
    logic got;
    got = 1'b0;
    @(negedge clk);
    i_cpu_req = 1'b1; i_cpu_wr = wr; i_cpu_sel = sel; i_cpu_din = din;
    for (int i = 0; i < 400 && !got; i++) begin
      if (o_cpu_ready) got = 1'b1;
      else begin
        if (rand_busy) i_screenBusy = ($urandom_range(0, 2) == 0);
        @(negedge clk);
      end
    end
    if (!got) begin
      n_tests++; n_fail++;
      $display("FAIL xfer_timeout: ready=%b required 1", o_cpu_ready);
    end
    i_vblank_pulse = vb;
    @(negedge clk);
    i_cpu_req = 1'b0; i_vblank_pulse = 1'b0;
    dout = o_cpu_dout; rv = o_cpu_rd_valid;
  endtask

  task automatic wait_idle();
    logic got;
    got = 1'b0;
    i_screenBusy = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (o_cpu_ready) got = 1'b1;
    end
    if (!got) begin
      n_tests++; n_fail++;
      $display("FAIL idle_timeout: ready=%b required 1", o_cpu_ready);
    end
  endtask

  task automatic wr_port(input logic sel, input logic [7:0] b);
    logic [7:0] d; logic v;
    xfer(1'b1, sel, b, 1'b0, d, v);
    wait_idle();
  endtask

  task automatic rd_port(input logic sel, input logic vb, output logic [7:0] d, output logic v);
    xfer(1'b0, sel, 8'h00, vb, d, v);
    wait_idle();
  endtask

  task automatic pulse(input logic vb, input logic ov, input logic co);
    @(negedge clk);
    i_vblank_pulse = vb; i_spr_ovf_pulse = ov; i_spr_coll_pulse = co;
    @(negedge clk);
    i_vblank_pulse = 1'b0; i_spr_ovf_pulse = 1'b0; i_spr_coll_pulse = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] d; logic v;
    i_rst = 1'b1;
    repeat (3) @(negedge clk);
    i_rst = 1'b0;
    n_tests++;
    if (o_cpu_ready !== 1'b1 || {o_VRAM_CPU_we, o_VRAM_CPU_re, o_CRAM_CPU_we} !== 3'b000 ||
        o_cpu_rd_valid !== 1'b0 || o_cpu_dout !== 8'h00 || o_irq !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: rdy=%b strb=%b%b%b rv=%b dout=%h irq=%b required 1 000 0 00 0",
               o_cpu_ready, o_VRAM_CPU_we, o_VRAM_CPU_re, o_CRAM_CPU_we, o_cpu_rd_valid,
               o_cpu_dout, o_irq);
    end
    n_tests++;
    if (o_regFile !== '0) begin
      n_fail++; $display("FAIL reset_regfile: got %h required 0", o_regFile);
    end
    clear_q();
    rd_port(1'b0, 1'b0, d, v);
    n_tests++;
    if (d !== 8'h00 || v !== 1'b1) begin
      n_fail++; $display("FAIL reset_readbuf: got %h rv=%b required 00 rv=1", d, v);
    end
    n_tests++;
    if (re_q.size() != 1 || re_head() !== 14'h0000) begin
      n_fail++; $display("FAIL reset_addr: got n=%0d %h required 1 0000", re_q.size(), re_head());
    end
  endtask

  task automatic test_vram_write();
    clear_q();
    wr_port(1'b1, 8'h00); wr_port(1'b1, 8'h40);
    wr_port(1'b0, 8'hAB);
    ref_vram[14'h0000] = 8'hAB;
    n_tests++;
    if (we_q.size() != 1 || we_head() !== {14'h0000, 8'hAB} || re_q.size() != 0) begin
      n_fail++; $display("FAIL vram_write0: got n=%0d %h required 1 %h", we_q.size(), we_head(),
                         {14'h0000, 8'hAB});
    end
    clear_q();
    wr_port(1'b0, 8'hCD);
    ref_vram[14'h0001] = 8'hCD;
    n_tests++;
    if (we_q.size() != 1 || we_head() !== {14'h0001, 8'hCD}) begin
      n_fail++; $display("FAIL vram_write_inc: got n=%0d %h required 1 %h", we_q.size(), we_head(),
                         {14'h0001, 8'hCD});
    end
  endtask

  task automatic test_reg_write();
    clear_q();
    wr_port(1'b1, 8'h34); wr_port(1'b1, 8'h81);
    n_tests++;
    if (o_regFile[15:8] !== 8'h34) begin
      n_fail++; $display("FAIL reg_write: got %h required 34", o_regFile[15:8]);
    end
    n_tests++;
    if (we_q.size() + re_q.size() + cram_q.size() != 0) begin
      n_fail++; $display("FAIL reg_no_strobe: got %0d strobes required 0",
                         we_q.size() + re_q.size() + cram_q.size());
    end
    wr_port(1'b1, 8'h02); wr_port(1'b1, 8'h40); wr_port(1'b0, 8'h11);
    ref_vram[14'h0002] = 8'h11;
    n_tests++;
    if (we_q.size() != 1 || we_head() !== {14'h0002, 8'h11}) begin
      n_fail++; $display("FAIL reg_second_cleared: got %h required %h", we_head(), {14'h0002, 8'h11});
    end
  endtask

  task automatic test_read_wrap();
    logic [7:0] d; logic v;
    wr_port(1'b1, 8'hFF); wr_port(1'b1, 8'h7F); wr_port(1'b0, 8'h5A);
    ref_vram[14'h3FFF] = 8'h5A;
    clear_q();
    wr_port(1'b1, 8'hFF); wr_port(1'b1, 8'h3F);
    n_tests++;
    if (re_q.size() != 1 || re_head() !== 14'h3FFF) begin
      n_fail++; $display("FAIL rd_prefetch: got n=%0d %h required 1 3fff", re_q.size(), re_head());
    end
    clear_q();
    rd_port(1'b0, 1'b0, d, v);
    n_tests++;
    if (d !== 8'h5A || v !== 1'b1) begin
      n_fail++; $display("FAIL rd_data: got %h rv=%b required 5a rv=1", d, v);
    end
    n_tests++;
    if (re_q.size() != 1 || re_head() !== 14'h0000) begin
      n_fail++; $display("FAIL rd_wrap: got n=%0d %h required 1 0000", re_q.size(), re_head());
    end
    rd_port(1'b0, 1'b0, d, v);
    n_tests++;
    if (d !== ref_vram[14'h0000]) begin
      n_fail++; $display("FAIL rd_after_wrap: got %h required %h", d, ref_vram[14'h0000]);
    end
  endtask

  task automatic test_busy();
    logic [7:0] d; logic v; int bad;
    wr_port(1'b1, 8'h10); wr_port(1'b1, 8'h41);
    clear_q();
    i_screenBusy = 1'b1;
    xfer(1'b1, 1'b0, 8'h99, 1'b0, d, v);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (we_q.size() != 0 || o_cpu_ready !== 1'b0 || o_VRAM_CPU_we !== 1'b0) bad++;
      @(negedge clk);
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++; $display("FAIL busy_hold: got %0d bad cycles required 0", bad);
    end
    i_screenBusy = 1'b0;
    @(negedge clk);
    ref_vram[14'h0110] = 8'h99;
    n_tests++;
    if (we_q.size() != 1 || we_head() !== {14'h0110, 8'h99}) begin
      n_fail++; $display("FAIL busy_release: got n=%0d %h required 1 %h", we_q.size(), we_head(),
                         {14'h0110, 8'h99});
    end
    wait_idle();
  endtask

  task automatic test_cram();
    logic [7:0] d; logic v;
    wr_port(1'b1, 8'h00); wr_port(1'b1, 8'hC0);
    clear_q();
    wr_port(1'b0, 8'h3F);
    n_tests++;
    if (cram_q.size() != 1 || cram_head() !== {5'd0, 6'h3F} || we_q.size() != 0) begin
      n_fail++; $display("FAIL cram_write0: got n=%0d %h required 1 %h", cram_q.size(), cram_head(),
                         {5'd0, 6'h3F});
    end
    clear_q();
    i_screenBusy = 1'b1;
    xfer(1'b1, 1'b0, 8'hFF, 1'b0, d, v);
    @(negedge clk);
    n_tests++;
    if (cram_q.size() != 1 || cram_head() !== {5'd1, 6'h3F}) begin
      n_fail++; $display("FAIL cram_busy_inc: got n=%0d %h required 1 %h", cram_q.size(),
                         cram_head(), {5'd1, 6'h3F});
    end
    wait_idle();
  endtask

  task automatic test_irq();
    logic [7:0] d; logic v;
    wr_port(1'b1, 8'h20); wr_port(1'b1, 8'h81);
    rd_port(1'b1, 1'b0, d, v);
    repeat (2) @(negedge clk);
    n_tests++;
    if (o_irq !== 1'b0) begin n_fail++; $display("FAIL irq_idle: got %b required 0", o_irq); end
    pulse(1'b1, 1'b0, 1'b0);
    @(negedge clk);
    n_tests++;
    if (o_irq !== 1'b1) begin n_fail++; $display("FAIL irq_set: got %b required 1", o_irq); end
    rd_port(1'b1, 1'b0, d, v);
    n_tests++;
    if (d !== 8'h80 || v !== 1'b1) begin
      n_fail++; $display("FAIL status_vint: got %h rv=%b required 80 rv=1", d, v);
    end
    @(negedge clk);
    n_tests++;
    if (o_irq !== 1'b0) begin n_fail++; $display("FAIL irq_clear: got %b required 0", o_irq); end
    pulse(1'b1, 1'b0, 1'b0);
    rd_port(1'b1, 1'b1, d, v);
    repeat (2) @(negedge clk);
    n_tests++;
    if (d !== 8'h80 || o_irq !== 1'b1) begin
      n_fail++; $display("FAIL set_wins: got %h irq=%b required 80 irq=1", d, o_irq);
    end
    rd_port(1'b1, 1'b0, d, v);
    n_tests++;
    if (d !== 8'h80) begin n_fail++; $display("FAIL status_kept: got %h required 80", d); end
    rd_port(1'b1, 1'b0, d, v);
    n_tests++;
    if (d !== 8'h00) begin n_fail++; $display("FAIL status_cleared: got %h required 00", d); end
    pulse(1'b0, 1'b1, 1'b1);
    repeat (2) @(negedge clk);
    n_tests++;
    if (o_irq !== 1'b0) begin n_fail++; $display("FAIL irq_spr_only: got %b required 0", o_irq); end
    rd_port(1'b1, 1'b0, d, v);
    n_tests++;
    if (d !== 8'h60) begin n_fail++; $display("FAIL status_spr: got %h required 60", d); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] d; logic v;
    wr_port(1'b1, 8'h00); wr_port(1'b1, 8'h40);
    clear_q();
    i_screenBusy = 1'b1;
    xfer(1'b1, 1'b0, 8'h77, 1'b0, d, v);
    repeat (3) @(negedge clk);
    i_rst = 1'b1;
    @(negedge clk);
    i_rst = 1'b0;
    @(negedge clk);
    i_screenBusy = 1'b0;
    repeat (5) @(negedge clk);
    n_tests++;
    if (we_q.size() != 0 || o_cpu_ready !== 1'b1 || o_regFile !== '0) begin
      n_fail++; $display("FAIL reset_mid: we_n=%0d rdy=%b regs=%h required 0 1 0", we_q.size(),
                         o_cpu_ready, o_regFile);
    end
  endtask

  task automatic test_random();
    logic [13:0] m_addr; logic [1:0] m_code; logic m_second; logic [7:0] m_buf;
    logic [7:0] m_regs [NUM_REGS];
    logic [7:0] b, d; logic v; int op, bad_rd, bad_st;
    int e_we_n, e_re_n, e_cr_n;
    logic [21:0] e_we; logic [13:0] e_re; logic [10:0] e_cr;
    @(negedge clk); i_rst = 1'b1; @(negedge clk); i_rst = 1'b0;
    m_addr = '0; m_code = '0; m_second = 1'b0; m_buf = '0;
    for (int i = 0; i < NUM_REGS; i++) m_regs[i] = 8'h00;
    bad_rd = 0; bad_st = 0;
    rand_busy = 1'b1;
    for (int n = 0; n < 250; n++) begin
      clear_q();
      e_we_n = 0; e_re_n = 0; e_cr_n = 0; e_we = '0; e_re = '0; e_cr = '0;
      op = $urandom_range(0, 9);
      b = 8'($urandom);
      if (op <= 3) begin
        xfer(1'b1, 1'b1, b, 1'b0, d, v);
        if (!m_second) begin
          m_addr[7:0] = b; m_second = 1'b1;
        end else begin
          m_second = 1'b0; m_code = b[7:6]; m_addr[13:8] = b[5:0];
          if (m_code == 2'd0) begin
            e_re_n = 1; e_re = m_addr; m_buf = ref_vram[m_addr]; m_addr = m_addr + 14'd1;
          end else if (m_code == 2'd2 && b[3:0] < NUM_REGS) begin
            m_regs[b[3:0]] = m_addr[7:0];
          end
        end
      end else if (op <= 6) begin
        xfer(1'b1, 1'b0, b, 1'b0, d, v);
        m_second = 1'b0; m_buf = b;
        if (m_code == 2'd3) begin e_cr_n = 1; e_cr = {m_addr[4:0], b[5:0]}; end
        else begin e_we_n = 1; e_we = {m_addr, b}; ref_vram[m_addr] = b; end
        m_addr = m_addr + 14'd1;
      end else if (op <= 8) begin
        xfer(1'b0, 1'b0, 8'h00, 1'b0, d, v);
        if (d !== m_buf || v !== 1'b1) begin
          bad_rd++; $display("FAIL rnd_read[%0d]: got %h rv=%b required %h rv=1", n, d, v, m_buf);
        end
        m_second = 1'b0;
        e_re_n = 1; e_re = m_addr; m_buf = ref_vram[m_addr]; m_addr = m_addr + 14'd1;
      end else begin
        xfer(1'b0, 1'b1, 8'h00, 1'b0, d, v);
        if (d !== 8'h00 || v !== 1'b1) begin
          bad_rd++; $display("FAIL rnd_status[%0d]: got %h rv=%b required 00 rv=1", n, d, v);
        end
        m_second = 1'b0;
      end
      wait_idle();
      if (we_q.size() != e_we_n || re_q.size() != e_re_n || cram_q.size() != e_cr_n ||
          (e_we_n == 1 && we_head() !== e_we) || (e_re_n == 1 && re_head() !== e_re) ||
          (e_cr_n == 1 && cram_head() !== e_cr)) begin
        bad_st++;
        $display("FAIL rnd_strobes[%0d]: got we=%0d/%h re=%0d/%h cr=%0d/%h required %0d/%h %0d/%h %0d/%h",
                 n, we_q.size(), we_head(), re_q.size(), re_head(), cram_q.size(), cram_head(),
                 e_we_n, e_we, e_re_n, e_re, e_cr_n, e_cr);
      end
    end
    rand_busy = 1'b0;
    i_screenBusy = 1'b0;
    n_tests++;
    if (bad_rd != 0) begin n_fail++; $display("FAIL rnd_reads: %0d bad required 0", bad_rd); end
    n_tests++;
    if (bad_st != 0) begin n_fail++; $display("FAIL rnd_memops: %0d bad required 0", bad_st); end
    for (int i = 0; i < NUM_REGS; i++) begin
      n_tests++;
      if (o_regFile[i*8 +: 8] !== m_regs[i]) begin
        n_fail++; $display("FAIL rnd_reg%0d: got %h required %h", i, o_regFile[i*8 +: 8], m_regs[i]);
      end
    end
  endtask

  task automatic test_strobe_rules();
    n_tests++;
    if (strobe_err != 0) begin
      n_fail++; $display("FAIL strobe_rules: got %0d violations required 0", strobe_err);
    end
  endtask

  initial begin
    i_rst = 1'b1; i_cpu_req = 1'b0; i_cpu_wr = 1'b0; i_cpu_sel = 1'b0; i_cpu_din = 8'h00;
    i_screenBusy = 1'b0; i_vblank_pulse = 1'b0; i_spr_ovf_pulse = 1'b0;
    i_spr_coll_pulse = 1'b0; i_line_pulse = 1'b0;
    for (int i = 0; i < 16384; i++) ref_vram[i] = 8'(i * 37 + 5);
    test_reset();
    test_vram_write();
    test_reg_write();
    test_read_wrap();
    test_busy();
    test_cram();
    test_irq();
    test_reset_mid();
    test_random();
    test_strobe_rules();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vdp_cpu_port.md
Name: vdp_cpu_port

Overview:
- CPU-facing side of the VDP: the writer into the VRAM, CRAM and register file that the display interface reads.
- Decodes Z80 control-port and data-port accesses:
  - two-byte command words;
  - VRAM read-ahead buffer;
  - VRAM/CRAM writes with address auto-increment;
  - register writes;
  - status read with flag clear.
- Owns regFile and the interrupt output.
- Yields VRAM to the display interface whenever screenBusy is high.

Parameters:
- VRAM_LAT, 2, cycles from VRAM_CPU_re to VRAM_CPU_data_out valid.
- NUM_REGS, 10, register file depth; writes to index >= NUM_REGS ignored (except as noted under Optional Feature).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- cpu_req  input  1  access request, held until accepted
- cpu_wr  input  1  1=write, 0=read
- cpu_sel  input  1  0=data port, 1=control port
- cpu_din  input  8  write byte
- cpu_ready  output  1  access accepted on cycle where cpu_req&&cpu_ready
- cpu_dout  output  8  read byte
- cpu_rd_valid  output  1  one-cycle pulse, cpu_dout valid
- screenBusy  input  1  display owns VRAM; no CPU VRAM op while high
- VRAM_CPU_addr  output  14  VRAM address
- VRAM_CPU_wdata  output  8  VRAM write data
- VRAM_CPU_we  output  1  VRAM write strobe
- VRAM_CPU_re  output  1  VRAM read strobe
- VRAM_CPU_data_out  input  8  VRAM read data
- CRAM_CPU_addr  output  5  CRAM address
- CRAM_CPU_wdata  output  6  CRAM write data
- CRAM_CPU_we  output  1  CRAM write strobe
- regFile  output  NUM_REGSx8  VDP registers
- vblank_pulse  input  1  frame-end event
- spr_ovf_pulse  input  1  sprite overflow event
- spr_coll_pulse  input  1  sprite collision event
- line_pulse  input  1  start of each active line (used only with the Optional Feature)
- irq  output  1  interrupt to CPU, level

Behaviour:
Reset:
- rst returns the FSM to IDLE on the same edge, even mid-operation.
- Clears:
  - all strobes, cpu_rd_valid, cpu_dout, irq;
  - regFile, addr, code, readBuf;
  - secondByte flag;
  - vint/ovf/coll flags.

Internal state:
- addr[13:0] and code[1:0].
- secondByte flag.
- readBuf[7:0].
- Status flags vint, ovf, coll.

FSM states and transitions:
- IDLE:
  - cpu_ready=1.
  - Control write, secondByte=0: latch addr[7:0]=din, set secondByte. Stays IDLE.
  - Control write, secondByte=1: code=din[7:6], addr[13:8]=din[5:0], clear secondByte.
    - code 0 -> RD_REQ (read-ahead).
    - code 2 -> regFile[din[3:0]] <= addr[7:0]; stays IDLE.
    - code 1 or 3 -> stays IDLE.
  - Control read: returns status {vint,ovf,coll,5'b0}, cpu_rd_valid next cycle; clears vint/ovf/coll and secondByte.
  - Data write: clears secondByte, readBuf<=din.
    - code 3 -> CRAM_WR.
    - otherwise -> VRAM_WR.
  - Data read: cpu_dout<=readBuf, cpu_rd_valid next cycle, clears secondByte -> RD_REQ.
- VRAM_WR:
  - cpu_ready=0.
  - Waits for screenBusy=0, then asserts VRAM_CPU_we 1 cycle with addr/latched data.
  - addr++ -> IDLE.
- CRAM_WR:
  - cpu_ready=0.
  - CRAM_CPU_we 1 cycle; CRAM_CPU_addr=addr[4:0], CRAM_CPU_wdata=latched[5:0]; not gated by screenBusy.
  - addr++ -> IDLE.
- RD_REQ:
  - cpu_ready=0.
  - Waits for screenBusy=0, then asserts VRAM_CPU_re 1 cycle -> RD_WAIT.
- RD_WAIT:
  - Counts VRAM_LAT cycles; readBuf<=VRAM_CPU_data_out.
  - addr++ -> IDLE.

Arithmetic and strobe rules:
- addr increments modulo 2^14 (3FFF -> 0000).
- At most one of VRAM_CPU_we / VRAM_CPU_re per cycle; neither while screenBusy=1.

Flags and interrupt:
- Pulse inputs set flags. Set wins over simultaneous status-read clear; the flag remains 1.
- irq = vint & regFile[1][5], registered, 1-cycle latency.

Optional Feature:
- Macro: VDP_LINE_IRQ_EN.
- With the macro:
  - Register write to index 10 loads an internal lineReload (not part of regFile).
  - An 8-bit line counter decrements on line_pulse.
  - Underflow sets lineFlag and reloads the counter; vblank_pulse also reloads it.
  - irq additionally ORs lineFlag & regFile[0][4].
  - Control-port status read clears lineFlag.
- Without the macro: index 10 writes are ignored, line_pulse is unused, and irq depends on vint only.

Test Plan:
- Control writes 0x00 then 0x40, data write 0xAB, screenBusy=0 -> VRAM_CPU_we with addr 0x0000, data 0xAB; addr becomes 0x0001.
- Control writes 0x34, 0x81 -> regFile[1]=0x34; no VRAM strobe; secondByte cleared.
- Setup read at 0x3FFF (0xFF, 0x3F) with VRAM[0x3FFF]=0x5A, then data read -> cpu_dout=0x5A; next prefetch at 0x0000 (wrap).
- screenBusy held 20 cycles during pending data write -> VRAM_CPU_we stays low and cpu_ready=0 until screenBusy falls; we asserts within 1 cycle after.
- regFile[1][5]=1, vblank_pulse -> irq=1; status read returns 0x80, irq drops. Repeat with vblank_pulse coincident with the read -> vint stays 1.
- Control writes 0x00, 0xC0, then data write 0x3F -> CRAM_CPU_we, addr 0, wdata 0x3F. Assert rst during a VRAM_WR wait -> no we, FSM in IDLE, regFile zero.
